// File: rtl/c3_custom_heap_instruction.sv
// -----------------------------------------------------------------------------
// c3_custom_heap_instruction
//
// Custom-instruction functional unit holding a min-heap priority queue of
// unsigned keys in internal registers. One instruction is accepted at a time
// from the issue path while IDLE; the opcode arrives on vrd1:
//   000 push, 001 pop, 010 peek, 011 clear, 100 init, others no-op.
// Completion is signalled by a one-cycle out_v pulse carrying the echoed tags,
// the heap root after the operation (0 when empty), the element count and the
// latched heap base address.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   in_v          instruction valid (one-cycle pulse, ignored while busy)
//   rd, vrd1, vrd2  destination tag / opcode / auxiliary tag
//   in_data       key for push
//   in_heap_addr  base address latched by init
//   in_heap_size  capacity limit latched by init (0 or >DEPTH means DEPTH)
//   out_v         completion pulse
//   out_rd, out_vrd1, out_vrd2  tags of the completed instruction
//   out_data      heap root after the operation, 0 if empty
//   out_heap_addr latched base address
//   out_heap_size current element count, zero-extended
// -----------------------------------------------------------------------------
module c3_custom_heap_instruction #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_v,
    input  logic [4:0]        rd,
    input  logic [2:0]        vrd1,
    input  logic [2:0]        vrd2,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_heap_addr,
    input  logic [31:0]       in_heap_size,
    output logic              out_v,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_vrd1,
    output logic [2:0]        out_vrd2,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_heap_addr,
    output logic [31:0]       out_heap_size
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_PEEK  = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b011;
    localparam logic [2:0] OP_INIT  = 3'b100;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIFT_UP   = 2'd1,
        SIFT_DOWN = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    cap_q, cap_d;
    logic [31:0]         base_q, base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4:0]          rd_q, rd_d;
    logic [2:0]          op_q, op_d;
    logic [2:0]          vrd2_q, vrd2_d;
    logic [DATA_W-1:0]   heap_q [DEPTH];
    logic [DATA_W-1:0]   heap_d [DEPTH];

    logic                out_v_q, out_v_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [2:0]          out_vrd1_q, out_vrd1_d;
    logic [2:0]          out_vrd2_q, out_vrd2_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [31:0]         out_heap_addr_q, out_heap_addr_d;
    logic [31:0]         out_heap_size_q, out_heap_size_d;

    // Tree navigation helpers. Children are one bit wider than count so that
    // 2*idx+2 never wraps for the last index.
    logic [IDX_W-1:0]    parent_s;
    logic [CNT_W:0]      left_s;
    logic [CNT_W:0]      right_s;
    logic                has_left_s;
    logic                has_right_s;
    logic [IDX_W-1:0]    child_s;

    assign parent_s    = (idx_q - {{(IDX_W-1){1'b0}}, 1'b1}) >> 1;
    assign left_s      = {1'b0, idx_q, 1'b1};
    assign right_s     = left_s + {{CNT_W{1'b0}}, 1'b1};
    assign has_left_s  = left_s  < {1'b0, count_q};
    assign has_right_s = right_s < {1'b0, count_q};
    // Right child only wins when strictly smaller, so ties go left.
    assign child_s     = (has_right_s &&
                          (heap_q[right_s[IDX_W-1:0]] < heap_q[left_s[IDX_W-1:0]]))
                         ? right_s[IDX_W-1:0] : left_s[IDX_W-1:0];

    // Next-state, heap update and completion-output computation.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        cap_d           = cap_q;
        base_d          = base_q;
        idx_d           = idx_q;
        rd_d            = rd_q;
        op_d            = op_q;
        vrd2_d          = vrd2_q;
        heap_d          = heap_q;
        out_v_d         = 1'b0;
        out_rd_d        = out_rd_q;
        out_vrd1_d      = out_vrd1_q;
        out_vrd2_d      = out_vrd2_q;
        out_data_d      = out_data_q;
        out_heap_addr_d = out_heap_addr_q;
        out_heap_size_d = out_heap_size_q;

        case (state_q)
            IDLE: begin
                if (in_v) begin
                    rd_d    = rd;
                    op_d    = vrd1;
                    vrd2_d  = vrd2;
                    state_d = DONE;
                    case (vrd1)
                        OP_PUSH: begin
                            if (count_q < cap_q) begin
                                heap_d[count_q[IDX_W-1:0]] = in_data;
                                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                                idx_d   = count_q[IDX_W-1:0];
                                state_d = SIFT_UP;
                            end else begin
                                state_d = DONE;
                            end
                        end
                        OP_POP: begin
                            if (count_q != {CNT_W{1'b0}}) begin
                                heap_d[0] = heap_q[count_q[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1}];
                                count_d   = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                                idx_d     = {IDX_W{1'b0}};
                                state_d   = SIFT_DOWN;
                            end else begin
                                state_d = DONE;
                            end
                        end
                        OP_PEEK: begin
                            state_d = DONE;
                        end
                        OP_CLEAR: begin
                            count_d = {CNT_W{1'b0}};
                        end
                        OP_INIT: begin
                            base_d  = in_heap_addr;
                            count_d = {CNT_W{1'b0}};
                            if ((in_heap_size == 32'd0) || (in_heap_size > 32'(DEPTH))) begin
                                cap_d = CNT_W'(DEPTH);
                            end else begin
                                cap_d = in_heap_size[CNT_W-1:0];
                            end
                        end
                        default: begin
                            state_d = DONE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            SIFT_UP: begin
                if ((idx_q == {IDX_W{1'b0}}) || (heap_q[parent_s] <= heap_q[idx_q])) begin
                    state_d = DONE;
                end else begin
                    heap_d[parent_s] = heap_q[idx_q];
                    heap_d[idx_q]    = heap_q[parent_s];
                    idx_d            = parent_s;
                end
            end
            SIFT_DOWN: begin
                if (!has_left_s || (heap_q[idx_q] <= heap_q[child_s])) begin
                    state_d = DONE;
                end else begin
                    heap_d[child_s] = heap_q[idx_q];
                    heap_d[idx_q]   = heap_q[child_s];
                    idx_d           = child_s;
                end
            end
            DONE: begin
                out_v_d         = 1'b1;
                out_rd_d        = rd_q;
                out_vrd1_d      = op_q;
                out_vrd2_d      = vrd2_q;
                out_data_d      = (count_q != {CNT_W{1'b0}}) ? heap_q[0] : {DATA_W{1'b0}};
                out_heap_size_d = 32'(count_q);
                out_heap_addr_d = base_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, tag and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            count_q         <= {CNT_W{1'b0}};
            cap_q           <= CNT_W'(DEPTH);
            base_q          <= 32'd0;
            idx_q           <= {IDX_W{1'b0}};
            rd_q            <= 5'd0;
            op_q            <= 3'd0;
            vrd2_q          <= 3'd0;
            out_v_q         <= 1'b0;
            out_rd_q        <= 5'd0;
            out_vrd1_q      <= 3'd0;
            out_vrd2_q      <= 3'd0;
            out_data_q      <= {DATA_W{1'b0}};
            out_heap_addr_q <= 32'd0;
            out_heap_size_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            cap_q           <= cap_d;
            base_q          <= base_d;
            idx_q           <= idx_d;
            rd_q            <= rd_d;
            op_q            <= op_d;
            vrd2_q          <= vrd2_d;
            out_v_q         <= out_v_d;
            out_rd_q        <= out_rd_d;
            out_vrd1_q      <= out_vrd1_d;
            out_vrd2_q      <= out_vrd2_d;
            out_data_q      <= out_data_d;
            out_heap_addr_q <= out_heap_addr_d;
            out_heap_size_q <= out_heap_size_d;
        end
    end

    // Heap storage; contents beyond count are never read, so no reset needed.
    always_ff @(posedge clk) begin
        heap_q <= heap_d;
    end

    assign out_v         = out_v_q;
    assign out_rd        = out_rd_q;
    assign out_vrd1      = out_vrd1_q;
    assign out_vrd2      = out_vrd2_q;
    assign out_data      = out_data_q;
    assign out_heap_addr = out_heap_addr_q;
    assign out_heap_size = out_heap_size_q;

endmodule

// File: tb/tb_c3_custom_heap_instruction.sv
// -----------------------------------------------------------------------------
// Testbench for c3_custom_heap_instruction: a table of instructions with
// hand-computed expected completions, followed by hand-written sequences for
// the capacity mapping of init and a reset in the middle of a sift-down.
// -----------------------------------------------------------------------------
module tb_c3_custom_heap_instruction;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        in_v;
    logic [4:0]  rd;
    logic [2:0]  vrd1;
    logic [2:0]  vrd2;
    logic [31:0] in_data;
    logic [31:0] in_heap_addr;
    logic [31:0] in_heap_size;
    logic        out_v;
    logic [4:0]  out_rd;
    logic [2:0]  out_vrd1;
    logic [2:0]  out_vrd2;
    logic [31:0] out_data;
    logic [31:0] out_heap_addr;
    logic [31:0] out_heap_size;

    int n_checks = 0;
    int n_errors = 0;

    c3_custom_heap_instruction #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_v          (in_v),
        .rd            (rd),
        .vrd1          (vrd1),
        .vrd2          (vrd2),
        .in_data       (in_data),
        .in_heap_addr  (in_heap_addr),
        .in_heap_size  (in_heap_size),
        .out_v         (out_v),
        .out_rd        (out_rd),
        .out_vrd1      (out_vrd1),
        .out_vrd2      (out_vrd2),
        .out_data      (out_data),
        .out_heap_addr (out_heap_addr),
        .out_heap_size (out_heap_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [2:0]  vrd2;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] size;
        logic [31:0] exp_data;
        logic [31:0] exp_size;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [4:0] r, input logic [2:0] v2,
                       input logic [31:0] d, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] ed, input logic [31:0] es, input logic [31:0] ea);
        vec_t v;
        v.op = op; v.rd = r; v.vrd2 = v2; v.data = d; v.addr = a; v.size = s;
        v.exp_data = ed; v.exp_size = es; v.exp_addr = ea;
        vecs.push_back(v);
    endtask

    // Issue one instruction and wait (bounded) for its completion pulse.
    task automatic issue(input logic [2:0] op, input logic [4:0] r, input logic [2:0] v2,
                         input logic [31:0] d, input logic [31:0] a, input logic [31:0] s,
                         output bit got);
        @(negedge clk);
        in_v = 1'b1; vrd1 = op; rd = r; vrd2 = v2;
        in_data = d; in_heap_addr = a; in_heap_size = s;
        @(negedge clk);
        in_v = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_v) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit got;
        issue(v.op, v.rd, v.vrd2, v.data, v.addr, v.size, got);
        check({tag, " completion"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, " out_data"}, out_data, v.exp_data);
            check({tag, " out_heap_size"}, out_heap_size, v.exp_size);
            check({tag, " out_heap_addr"}, out_heap_addr, v.exp_addr);
            check({tag, " out_vrd1"}, {29'd0, out_vrd1}, {29'd0, v.op});
            check({tag, " out_rd"}, {27'd0, out_rd}, {27'd0, v.rd});
            check({tag, " out_vrd2"}, {29'd0, out_vrd2}, {29'd0, v.vrd2});
            @(negedge clk);
            check({tag, " out_v pulse"}, {31'd0, out_v}, 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit got;
        bit saw_v;
        reset = 1'b1; in_v = 1'b0; rd = 5'd0; vrd1 = 3'd0; vrd2 = 3'd0;
        in_data = 32'd0; in_heap_addr = 32'd0; in_heap_size = 32'd0;
        repeat (3) @(negedge clk);
        check("reset out_v", {31'd0, out_v}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset out_heap_size", out_heap_size, 32'd0);
        check("reset out_heap_addr", out_heap_addr, 32'd0);
        check("reset tags", {21'd0, out_rd, out_vrd1, out_vrd2}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // op, rd, vrd2, data, addr, size, exp_data, exp_size, exp_addr
        add(3'b000, 5'd1, 3'd1, 32'd10, 32'd0, 32'd0, 32'd10, 32'd1, 32'd0);
        add(3'b000, 5'd2, 3'd2, 32'd20, 32'd0, 32'd0, 32'd10, 32'd2, 32'd0);
        add(3'b000, 5'd3, 3'd3, 32'd15, 32'd0, 32'd0, 32'd10, 32'd3, 32'd0);
        add(3'b010, 5'd4, 3'd4, 32'd0,  32'd0, 32'd0, 32'd10, 32'd3, 32'd0);
        add(3'b001, 5'd5, 3'd5, 32'd0,  32'd0, 32'd0, 32'd15, 32'd2, 32'd0);
        add(3'b001, 5'd6, 3'd6, 32'd0,  32'd0, 32'd0, 32'd20, 32'd1, 32'd0);
        add(3'b001, 5'd7, 3'd7, 32'd0,  32'd0, 32'd0, 32'd0,  32'd0, 32'd0);
        add(3'b001, 5'd8, 3'd0, 32'd0,  32'd0, 32'd0, 32'd0,  32'd0, 32'd0);
        for (int k = DEPTH; k >= 1; k--) begin
            add(3'b000, 5'd9, 3'd1, 32'(k), 32'd0, 32'd0, 32'(k), 32'(DEPTH - k + 1), 32'd0);
        end
        add(3'b000, 5'd10, 3'd2, 32'd0, 32'd0, 32'd0, 32'd1, 32'(DEPTH), 32'd0);
        add(3'b111, 5'd11, 3'd3, 32'd0, 32'd0, 32'd0, 32'd1, 32'(DEPTH), 32'd0);
        add(3'b011, 5'd12, 3'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        // 5,3,8,1,9,2,7 then seven pops
        add(3'b000, 5'd7, 3'd5, 32'd5, 32'd0, 32'd0, 32'd5, 32'd1, 32'd0);
        add(3'b000, 5'd7, 3'd5, 32'd3, 32'd0, 32'd0, 32'd3, 32'd2, 32'd0);
        add(3'b000, 5'd7, 3'd5, 32'd8, 32'd0, 32'd0, 32'd3, 32'd3, 32'd0);
        add(3'b000, 5'd7, 3'd5, 32'd1, 32'd0, 32'd0, 32'd1, 32'd4, 32'd0);
        add(3'b000, 5'd7, 3'd5, 32'd9, 32'd0, 32'd0, 32'd1, 32'd5, 32'd0);
        add(3'b000, 5'd7, 3'd5, 32'd2, 32'd0, 32'd0, 32'd1, 32'd6, 32'd0);
        add(3'b000, 5'd7, 3'd5, 32'd7, 32'd0, 32'd0, 32'd1, 32'd7, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd2, 32'd6, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd3, 32'd5, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'd4, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd7, 32'd3, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd8, 32'd2, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd9, 32'd1, 32'd0);
        add(3'b001, 5'd7, 3'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        // init with capacity 2, then overflow and clear
        add(3'b100, 5'd13, 3'd6, 32'd0, 32'h1000, 32'd2, 32'd0, 32'd0, 32'h1000);
        add(3'b000, 5'd14, 3'd7, 32'd4, 32'd0, 32'd0, 32'd4, 32'd1, 32'h1000);
        add(3'b000, 5'd15, 3'd0, 32'd6, 32'd0, 32'd0, 32'd4, 32'd2, 32'h1000);
        add(3'b000, 5'd16, 3'd1, 32'd1, 32'd0, 32'd0, 32'd4, 32'd2, 32'h1000);
        add(3'b011, 5'd17, 3'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1000);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // init with size 0 maps capacity to DEPTH: DEPTH+1 ascending pushes
        issue(3'b100, 5'd1, 3'd1, 32'd0, 32'h2000, 32'd0, got);
        check("init0 completion", {31'd0, got}, 32'd1);
        for (int k = 0; k <= DEPTH; k++) begin
            issue(3'b000, 5'd2, 3'd2, 32'(100 + k), 32'd0, 32'd0, got);
            repeat (2) @(negedge clk);
        end
        check("init0 completion last", {31'd0, got}, 32'd1);
        check("init0 size", out_heap_size, 32'(DEPTH));
        check("init0 root", out_data, 32'd100);
        check("init0 addr", out_heap_addr, 32'h2000);

        // reset during sift-down of a pop on a 7-entry heap
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            logic [31:0] keys [7];
            keys = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7};
            issue(3'b000, 5'd3, 3'd3, keys[k], 32'd0, 32'd0, got);
            repeat (2) @(negedge clk);
        end
        check("rst7 size", out_heap_size, 32'd7);
        @(negedge clk);
        in_v = 1'b1; vrd1 = 3'b001; rd = 5'd9; vrd2 = 3'd4;
        @(negedge clk);
        in_v = 1'b0; reset = 1'b1;
        saw_v = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_v) saw_v = 1'b1;
        end
        check("rstmid no out_v", {31'd0, saw_v}, 32'd0);
        check("rstmid out_data", out_data, 32'd0);
        check("rstmid out_heap_size", out_heap_size, 32'd0);
        check("rstmid out_heap_addr", out_heap_addr, 32'd0);
        check("rstmid tags", {21'd0, out_rd, out_vrd1, out_vrd2}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        saw_v = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_v) saw_v = 1'b1;
        end
        check("rstmid still no out_v", {31'd0, saw_v}, 32'd0);
        issue(3'b000, 5'd21, 3'd6, 32'd42, 32'd0, 32'd0, got);
        check("post-reset push completion", {31'd0, got}, 32'd1);
        check("post-reset push data", out_data, 32'd42);
        check("post-reset push size", out_heap_size, 32'd1);
        check("post-reset push rd", {27'd0, out_rd}, 32'd21);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
